// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the rvga pipeline controller: register index, controller
// state encoding and the grouped stall/flush bundle.
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;

    typedef logic [REG_W-1:0] rvga_reg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } rvga_ctrl_state;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic stall_wb;
        logic flush_id;
        logic flush_ex;
    } rvga_stall_s;

    localparam rvga_stall_s STALL_NONE     = rvga_stall_s'(7'b00000_00);
    localparam rvga_stall_s STALL_ALL      = rvga_stall_s'(7'b11111_00);
    localparam rvga_stall_s STALL_REDIRECT = rvga_stall_s'(7'b00000_11);
    localparam rvga_stall_s STALL_BUBBLE   = rvga_stall_s'(7'b11000_01);

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// Combinational load-use comparator between the decode operands and the load
// sitting in execute; also intended for reuse by the forwarding unit.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1_i,
    input  logic [REG_W-1:0] id_rs2_i,
    input  logic             id_rs1_r_v_i,
    input  logic             id_rs2_r_v_i,
    input  logic [REG_W-1:0] ex_rd_i,
    input  logic             ex_ld_v_i,
    output logic             hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = id_rs1_r_v_i && (id_rs1_i == ex_rd_i);
    assign rs2_match = id_rs2_r_v_i && (id_rs2_i == ex_rd_i);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard_o  = ex_ld_v_i && (ex_rd_i != '0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage rvga pipeline: load-use bubbles,
// redirects, data-memory waits with a sticky timeout, halt/resume, perf counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH_P = 32,
    parameter int unsigned TIMEOUT_P   = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [REG_W-1:0]       id_rs1_i,
    input  logic [REG_W-1:0]       id_rs2_i,
    input  logic                   id_rs1_r_v_i,
    input  logic                   id_rs2_r_v_i,
    input  logic [REG_W-1:0]       ex_rd_i,
    input  logic                   ex_ld_v_i,
    input  logic                   redirect_v_i,
    input  logic                   dmem_req_v_i,
    input  logic                   dmem_ack_i,
    input  logic                   halt_v_i,
    input  logic                   resume_i,
    output logic                   stall_if_o,
    output logic                   stall_id_o,
    output logic                   stall_ex_o,
    output logic                   stall_mem_o,
    output logic                   stall_wb_o,
    output logic                   flush_id_o,
    output logic                   flush_ex_o,
    output logic                   halted_o,
    output logic                   timeout_o,
    output logic [CNT_WIDTH_P-1:0] stall_cnt_o,
    output logic [CNT_WIDTH_P-1:0] bubble_cnt_o
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT_P + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT_P);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    rvga_ctrl_state          state_q, state_d;
    logic [WAIT_W-1:0]       wait_cnt_q, wait_cnt_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_WIDTH_P-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH_P-1:0]  bubble_cnt_q, bubble_cnt_d;

    logic                    hazard;
    rvga_stall_s             run_ctrl;
    logic                    run_bubble;
    rvga_stall_s             ctrl;
    rvga_stall_s             ctrl_out;
    logic                    bubble;

    hazard_detect u_hazard (
        .id_rs1_i     (id_rs1_i),
        .id_rs2_i     (id_rs2_i),
        .id_rs1_r_v_i (id_rs1_r_v_i),
        .id_rs2_r_v_i (id_rs2_r_v_i),
        .ex_rd_i      (ex_rd_i),
        .ex_ld_v_i    (ex_ld_v_i),
        .hazard_o     (hazard)
    );

    // Redirect/load-use response shared by RUN and the MEM_WAIT ack cycle.
    assign run_ctrl   = redirect_v_i ? STALL_REDIRECT :
                        hazard       ? STALL_BUBBLE   : STALL_NONE;
    assign run_bubble = !redirect_v_i && hazard;

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctrl       = STALL_NONE;
        bubble     = 1'b0;

        unique case (state_q)
            RUN: begin
                if (halt_v_i) begin
                    ctrl    = STALL_ALL;
                    state_d = HALTED;
                end else if (dmem_req_v_i && !dmem_ack_i) begin
                    ctrl       = STALL_ALL;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end else begin
                    ctrl   = run_ctrl;
                    bubble = run_bubble;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ack_i) begin
                    ctrl       = STALL_ALL;
                    wait_cnt_d = (wait_cnt_q == TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + WAIT_ONE;
                end else begin
                    ctrl       = run_ctrl;
                    bubble     = run_bubble;
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            HALTED: begin
                ctrl = STALL_ALL;
                if (resume_i) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign timeout_d    = timeout_q || (wait_cnt_d == TIMEOUT_C);
    assign stall_cnt_d  = stall_cnt_q + CNT_WIDTH_P'(ctrl.stall_wb);
    assign bubble_cnt_d = bubble_cnt_q + CNT_WIDTH_P'(bubble);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            timeout_q    <= timeout_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Held inputs could otherwise re-assert stalls while reset is still active.
    assign ctrl_out = rst_i ? STALL_NONE : ctrl;

    assign stall_if_o   = ctrl_out.stall_if;
    assign stall_id_o   = ctrl_out.stall_id;
    assign stall_ex_o   = ctrl_out.stall_ex;
    assign stall_mem_o  = ctrl_out.stall_mem;
    assign stall_wb_o   = ctrl_out.stall_wb;
    assign flush_id_o   = ctrl_out.flush_id;
    assign flush_ex_o   = ctrl_out.flush_ex;
    assign halted_o     = (state_q == HALTED);
    assign timeout_o    = timeout_q;
    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;

endmodule
